// File: rtl/vcu_bram_arbiter_if.sv
// Host and VCU request ports into the BRAM arbiter. The master modport is the
// requester side; the slave modport is the arbiter side.
interface vcu_bram_arbiter_if #(
  parameter int wordSize  = 32,
  parameter int memDepthC = 32
);
  logic                  h_req;
  logic [wordSize/8-1:0] h_we;
  logic [memDepthC-1:0]  h_addr;
  logic [wordSize-1:0]   h_wdata;
  logic                  h_gnt;
  logic                  h_rvalid;
  logic [wordSize-1:0]   h_rdata;

  logic                  v_req;
  logic [wordSize/8-1:0] v_we;
  logic [memDepthC-1:0]  v_addr;
  logic [wordSize-1:0]   v_wdata;
  logic                  v_gnt;
  logic                  v_rvalid;
  logic [wordSize-1:0]   v_rdata;

  modport master (
    output h_req, h_we, h_addr, h_wdata,
    input  h_gnt, h_rvalid, h_rdata,
    output v_req, v_we, v_addr, v_wdata,
    input  v_gnt, v_rvalid, v_rdata
  );

  modport slave (
    input  h_req, h_we, h_addr, h_wdata,
    output h_gnt, h_rvalid, h_rdata,
    input  v_req, v_we, v_addr, v_wdata,
    output v_gnt, v_rvalid, v_rdata
  );
endinterface

// File: rtl/vcu_bram_arbiter.sv
// Shares one BRAM port between the host loader and the VCU, and sequences the
// LOAD -> RUN -> DONE phases of a VCU run.
module vcu_bram_arbiter #(
  parameter int wordSize  = 32,
  parameter int memDepthC = 32,
  parameter int RD_LAT    = 1
) (
  input  logic                   clk,
  input  logic                   RESET,
  input  logic                   memWRTDone,
  output logic                   vcu_start,
  input  logic                   vcu_done,
  output logic                   done,
  vcu_bram_arbiter_if.slave      bus,
  input  logic [wordSize-1:0]    BRAMdataIn,
  output logic [wordSize-1:0]    BRAMDataOut,
  output logic [memDepthC-1:0]   BRAMaddrByte,
  output logic [wordSize/8-1:0]  BRAMWREN,
  output logic                   BRAMENMEM
);
  localparam int BeW = wordSize / 8;

  typedef enum logic [1:0] {
    ST_LOAD = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic              rr_v_q, rr_v_d;        // 1: VCU held the last grant
  logic              vcu_start_q, vcu_start_d;
  logic [RD_LAT-1:0] pipe_vld_q, pipe_vld_d;
  logic [RD_LAT-1:0] pipe_own_q, pipe_own_d; // 1: read belongs to the VCU

  logic h_gnt_s;
  logic v_gnt_s;
  logic p_empty_s;
  logic rd_acc_s;

  assign p_empty_s = (pipe_vld_q == {RD_LAT{1'b0}});
  assign rd_acc_s  = (h_gnt_s && (bus.h_we == {BeW{1'b0}})) ||
                     (v_gnt_s && (bus.v_we == {BeW{1'b0}}));

  // Grant selection; everything is forced low while RESET is asserted.
  always_comb begin
    h_gnt_s = 1'b0;
    v_gnt_s = 1'b0;
    if (RESET) begin
      h_gnt_s = 1'b0;
      v_gnt_s = 1'b0;
    end else if (state_q == ST_RUN) begin
      if (bus.h_req && bus.v_req) begin
        h_gnt_s = rr_v_q;
        v_gnt_s = ~rr_v_q;
      end else begin
        h_gnt_s = bus.h_req;
        v_gnt_s = bus.v_req;
      end
    end else begin
      h_gnt_s = bus.h_req;
    end
  end

  // BRAM port drive from the granted requester, word-aligned address.
  always_comb begin
    BRAMENMEM    = 1'b0;
    BRAMWREN     = {BeW{1'b0}};
    BRAMaddrByte = {memDepthC{1'b0}};
    BRAMDataOut  = {wordSize{1'b0}};
    if (h_gnt_s) begin
      BRAMENMEM    = 1'b1;
      BRAMWREN     = bus.h_we;
      BRAMaddrByte = {bus.h_addr[memDepthC-1:2], 2'b00};
      BRAMDataOut  = bus.h_wdata;
    end else if (v_gnt_s) begin
      BRAMENMEM    = 1'b1;
      BRAMWREN     = bus.v_we;
      BRAMaddrByte = {bus.v_addr[memDepthC-1:2], 2'b00};
      BRAMDataOut  = bus.v_wdata;
    end else begin
      BRAMENMEM    = 1'b0;
    end
  end

  // Phase sequencing; the load phase waits for outstanding reads to drain.
  always_comb begin
    state_d     = state_q;
    vcu_start_d = 1'b0;
    case (state_q)
      ST_LOAD: begin
        if (memWRTDone && p_empty_s) begin
          state_d     = ST_RUN;
          vcu_start_d = 1'b1;
        end else begin
          state_d = ST_LOAD;
        end
      end
      ST_RUN: begin
        if (vcu_done) begin
          state_d = ST_DONE;
        end else begin
          state_d = ST_RUN;
        end
      end
      ST_DONE: begin
        if (!memWRTDone) begin
          state_d = ST_LOAD;
        end else begin
          state_d = ST_DONE;
        end
      end
      default: begin
        state_d = ST_LOAD;
      end
    endcase
  end

  // Round-robin pointer and read-return shift register.
  always_comb begin
    rr_v_d     = rr_v_q;
    pipe_vld_d = pipe_vld_q;
    pipe_own_d = pipe_own_q;
    if (h_gnt_s) begin
      rr_v_d = 1'b0;
    end else if (v_gnt_s) begin
      rr_v_d = 1'b1;
    end else begin
      rr_v_d = rr_v_q;
    end
    pipe_vld_d[0] = rd_acc_s;
    pipe_own_d[0] = v_gnt_s;
    for (int i = 1; i < RD_LAT; i++) begin
      pipe_vld_d[i] = pipe_vld_q[i-1];
      pipe_own_d[i] = pipe_own_q[i-1];
    end
  end

  // State registers.
  always_ff @(posedge clk or posedge RESET) begin
    if (RESET) begin
      state_q     <= ST_LOAD;
      rr_v_q      <= 1'b1;
      vcu_start_q <= 1'b0;
      pipe_vld_q  <= {RD_LAT{1'b0}};
      pipe_own_q  <= {RD_LAT{1'b0}};
    end else begin
      state_q     <= state_d;
      rr_v_q      <= rr_v_d;
      vcu_start_q <= vcu_start_d;
      pipe_vld_q  <= pipe_vld_d;
      pipe_own_q  <= pipe_own_d;
    end
  end

  assign vcu_start    = vcu_start_q;
  assign done         = (state_q == ST_DONE);
  assign bus.h_gnt    = h_gnt_s;
  assign bus.v_gnt    = v_gnt_s;
  assign bus.h_rvalid = pipe_vld_q[RD_LAT-1] & ~pipe_own_q[RD_LAT-1];
  assign bus.v_rvalid = pipe_vld_q[RD_LAT-1] &  pipe_own_q[RD_LAT-1];
  assign bus.h_rdata  = RESET ? {wordSize{1'b0}} : BRAMdataIn;
  assign bus.v_rdata  = RESET ? {wordSize{1'b0}} : BRAMdataIn;

endmodule

// File: tb/tb_vcu_bram_arbiter.sv
// Bench for vcu_bram_arbiter: directed vectors, hand-written sequences and a
// randomized run compared against a transaction-level model of the arbiter.
module tb_vcu_bram_arbiter;
  localparam int WS  = 32;
  localparam int AW  = 32;
  localparam int BW  = WS / 8;
  localparam int LAT = 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst, mem_wrt_done, vcu_done, vcu_start, done;
  logic [WS-1:0] bram_din, bram_dout;
  logic [AW-1:0] bram_addr;
  logic [BW-1:0] bram_wren;
  logic          bram_en;
  vcu_bram_arbiter_if #(.wordSize(WS), .memDepthC(AW)) bus ();

  vcu_bram_arbiter #(.wordSize(WS), .memDepthC(AW), .RD_LAT(LAT)) u_dut (
    .clk(clk), .RESET(rst), .memWRTDone(mem_wrt_done), .vcu_start(vcu_start),
    .vcu_done(vcu_done), .done(done), .bus(bus), .BRAMdataIn(bram_din),
    .BRAMDataOut(bram_dout), .BRAMaddrByte(bram_addr), .BRAMWREN(bram_wren),
    .BRAMENMEM(bram_en));

  logic          rst2, mwd2, vd2, start2, done2;
  logic [WS-1:0] din2, dout2;
  logic [AW-1:0] addr2;
  logic [BW-1:0] wren2;
  logic          en2;
  vcu_bram_arbiter_if #(.wordSize(WS), .memDepthC(AW)) bus2 ();

  vcu_bram_arbiter #(.wordSize(WS), .memDepthC(AW), .RD_LAT(2)) u_dut2 (
    .clk(clk), .RESET(rst2), .memWRTDone(mwd2), .vcu_start(start2),
    .vcu_done(vd2), .done(done2), .bus(bus2), .BRAMdataIn(din2),
    .BRAMDataOut(dout2), .BRAMaddrByte(addr2), .BRAMWREN(wren2),
    .BRAMENMEM(en2));

  int n_checks = 0;
  int n_err    = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s (t=%0t): got 0x%0h, expected 0x%0h", name, $time, act, exp);
    end
  endtask

  // Transaction-level model: phase, last granted port, reads awaiting return, memory image.
  typedef struct {
    logic          own_v;
    int            due;
    logic [WS-1:0] data;
  } rd_t;

  rd_t           pend[$];
  logic [WS-1:0] mem [int];
  int            phase   = 0;   // 0 LOAD, 1 RUN, 2 DONE
  logic          last_v  = 1'b1;
  logic          start_now = 1'b0;
  int            cyc     = 0;
  logic          m_hg, m_vg;

  logic obs_hg, obs_vg, obs_en, obs_hrv, obs_vrv, obs_done, obs_start;
  logic [AW-1:0] obs_addr;
  logic [BW-1:0] obs_wren;
  logic [WS-1:0] obs_hrdata;

  function automatic logic [WS-1:0] mem_rd(input logic [AW-1:0] a);
    int k;
    k = int'(a >> 2);
    return mem.exists(k) ? mem[k] : 32'h0;
  endfunction

  function automatic void mem_wr(input logic [AW-1:0] a, input logic [BW-1:0] we,
                                 input logic [WS-1:0] d);
    logic [WS-1:0] w;
    w = mem_rd(a);
    for (int b = 0; b < BW; b++) begin
      if (we[b]) w[8*b +: 8] = d[8*b +: 8];
    end
    mem[int'(a >> 2)] = w;
  endfunction

  // One clock cycle of the main DUT: check all outputs at negedge, advance the model at posedge.
  task automatic tick();
    logic          exp_en, exp_hrv, exp_vrv, p_empty;
    logic [BW-1:0] exp_wren;
    logic [AW-1:0] exp_addr;
    logic [WS-1:0] exp_dout, exp_rdata;
    rd_t           tmp;
    if (pend.size() > 0 && pend[0].due == cyc) bram_din = pend[0].data;
    else bram_din = $urandom();
    @(negedge clk);
    m_hg = 1'b0;
    m_vg = 1'b0;
    if (!rst) begin
      if (phase == 1) begin
        if (bus.h_req && bus.v_req) begin
          m_hg = last_v;
          m_vg = !last_v;
        end else begin
          m_hg = bus.h_req;
          m_vg = bus.v_req;
        end
      end else begin
        m_hg = bus.h_req;
      end
    end
    exp_en   = m_hg | m_vg;
    exp_wren = m_hg ? bus.h_we : (m_vg ? bus.v_we : 4'h0);
    exp_addr = m_hg ? (bus.h_addr & ~32'h3) : (m_vg ? (bus.v_addr & ~32'h3) : 32'h0);
    exp_dout = m_hg ? bus.h_wdata : (m_vg ? bus.v_wdata : 32'h0);
    exp_hrv  = !rst && pend.size() > 0 && pend[0].due == cyc && !pend[0].own_v;
    exp_vrv  = !rst && pend.size() > 0 && pend[0].due == cyc &&  pend[0].own_v;
    exp_rdata = rst ? 32'h0 : bram_din;
    check("h_gnt", bus.h_gnt, m_hg);
    check("v_gnt", bus.v_gnt, m_vg);
    check("BRAMENMEM", bram_en, exp_en);
    check("BRAMWREN", bram_wren, exp_wren);
    check("BRAMaddrByte", bram_addr, exp_addr);
    check("BRAMDataOut", bram_dout, exp_dout);
    check("vcu_start", vcu_start, !rst && start_now);
    check("done", done, !rst && phase == 2);
    check("h_rvalid", bus.h_rvalid, exp_hrv);
    check("v_rvalid", bus.v_rvalid, exp_vrv);
    check("h_rdata", bus.h_rdata, exp_rdata);
    check("v_rdata", bus.v_rdata, exp_rdata);
    obs_hg = bus.h_gnt;   obs_vg = bus.v_gnt;     obs_en = bram_en;
    obs_hrv = bus.h_rvalid; obs_vrv = bus.v_rvalid; obs_done = done;
    obs_start = vcu_start; obs_addr = bram_addr;  obs_wren = bram_wren;
    obs_hrdata = bus.h_rdata;
    @(posedge clk);
    if (rst) begin
      phase = 0; last_v = 1'b1; start_now = 1'b0; pend.delete();
    end else begin
      p_empty = (pend.size() == 0);
      if (pend.size() > 0 && pend[0].due == cyc) tmp = pend.pop_front();
      start_now = 1'b0;
      if (phase == 0 && mem_wrt_done && p_empty) begin
        phase = 1; start_now = 1'b1;
      end else if (phase == 1 && vcu_done) begin
        phase = 2;
      end else if (phase == 2 && !mem_wrt_done) begin
        phase = 0;
      end
      if (m_hg) begin
        last_v = 1'b0;
        if (bus.h_we == 4'h0) pend.push_back('{1'b0, cyc + LAT, mem_rd(bus.h_addr)});
        else mem_wr(bus.h_addr, bus.h_we, bus.h_wdata);
      end else if (m_vg) begin
        last_v = 1'b1;
        if (bus.v_we == 4'h0) pend.push_back('{1'b1, cyc + LAT, mem_rd(bus.v_addr)});
        else mem_wr(bus.v_addr, bus.v_we, bus.v_wdata);
      end
    end
    cyc++;
    #1;
  endtask

  typedef struct {
    logic          h_req;
    logic [BW-1:0] h_we;
    logic [AW-1:0] h_addr;
    logic [WS-1:0] h_wdata;
    logic          v_req;
    logic          e_hg;
    logic          e_vg;
    logic          e_en;
    logic [BW-1:0] e_wren;
    logic [AW-1:0] e_addr;
  } vec_t;

  vec_t vecs [7];
  logic gh [5], gv [5], rh [5], rv [5];
  int   cnt;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{1'b1, 4'hF, 32'h10, 32'hDEADBEEF, 1'b0, 1'b1, 1'b0, 1'b1, 4'hF, 32'h10};
    vecs[1] = '{1'b0, 4'h0, 32'h14, 32'h0,        1'b1, 1'b0, 1'b0, 1'b0, 4'h0, 32'h0};
    vecs[2] = '{1'b1, 4'h3, 32'h23, 32'h12345678, 1'b1, 1'b1, 1'b0, 1'b1, 4'h3, 32'h20};
    vecs[3] = '{1'b1, 4'h0, 32'h27, 32'h0,        1'b0, 1'b1, 1'b0, 1'b1, 4'h0, 32'h24};
    vecs[4] = '{1'b0, 4'h0, 32'h0,  32'h0,        1'b1, 1'b0, 1'b0, 1'b0, 4'h0, 32'h0};
    vecs[5] = '{1'b1, 4'hC, 32'h3E, 32'hA5A50000, 1'b0, 1'b1, 1'b0, 1'b1, 4'hC, 32'h3C};
    vecs[6] = '{1'b0, 4'h0, 32'h0,  32'h0,        1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 32'h0};

    rst = 1'b1; mem_wrt_done = 1'b0; vcu_done = 1'b0; bram_din = 32'h0;
    bus.h_req = 1'b0; bus.h_we = 4'h0; bus.h_addr = 32'h0; bus.h_wdata = 32'h0;
    bus.v_req = 1'b0; bus.v_we = 4'h0; bus.v_addr = 32'h0; bus.v_wdata = 32'h0;
    rst2 = 1'b1; mwd2 = 1'b0; vd2 = 1'b0; din2 = 32'h0;
    bus2.h_req = 1'b0; bus2.h_we = 4'h0; bus2.h_addr = 32'h0; bus2.h_wdata = 32'h0;
    bus2.v_req = 1'b0; bus2.v_we = 4'h0; bus2.v_addr = 32'h0; bus2.v_wdata = 32'h0;

    // Reset: every output low, even with requests pending.
    bus.h_req = 1'b1;
    tick();
    tick();
    bus.h_req = 1'b0;
    rst = 1'b0;

    // Directed vectors in LOAD.
    for (int i = 0; i < 7; i++) begin
      bus.h_req = vecs[i].h_req; bus.h_we = vecs[i].h_we;
      bus.h_addr = vecs[i].h_addr; bus.h_wdata = vecs[i].h_wdata;
      bus.v_req = vecs[i].v_req; bus.v_we = 4'h0; bus.v_addr = 32'h8;
      bus.v_wdata = $urandom();
      tick();
      check($sformatf("vec%0d h_gnt", i), obs_hg, vecs[i].e_hg);
      check($sformatf("vec%0d v_gnt", i), obs_vg, vecs[i].e_vg);
      check($sformatf("vec%0d BRAMENMEM", i), obs_en, vecs[i].e_en);
      check($sformatf("vec%0d BRAMWREN", i), obs_wren, vecs[i].e_wren);
      check($sformatf("vec%0d BRAMaddrByte", i), obs_addr, vecs[i].e_addr);
    end

    // VCU locked out in LOAD, then load complete starts the run.
    bus.h_req = 1'b0; bus.v_req = 1'b1; bus.v_we = 4'h0; bus.v_addr = 32'h8;
    tick();
    check("load v_gnt", obs_vg, 1'b0);
    check("load no access", obs_en, 1'b0);
    mem_wrt_done = 1'b1;
    cnt = 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      cnt += int'(obs_start);
    end
    check("vcu_start pulses", cnt, 1);
    check("run v_gnt", obs_vg, 1'b1);

    // Both ports read: alternating grants, rvalid one cycle later on the owner.
    bus.h_req = 1'b1; bus.h_we = 4'h0; bus.h_addr = 32'h10;
    bus.v_req = 1'b1; bus.v_we = 4'h0; bus.v_addr = 32'h20;
    for (int k = 0; k < 5; k++) begin
      if (k == 4) begin
        bus.h_req = 1'b0; bus.v_req = 1'b0;
      end
      tick();
      gh[k] = obs_hg; gv[k] = obs_vg; rh[k] = obs_hrv; rv[k] = obs_vrv;
    end
    for (int k = 0; k < 4; k++) begin
      check($sformatf("rr h_gnt %0d", k), gh[k], (k % 2) == 0);
      check($sformatf("rr v_gnt %0d", k), gv[k], (k % 2) == 1);
      check($sformatf("rr h_rvalid %0d", k + 1), rh[k+1], (k % 2) == 0);
      check($sformatf("rr v_rvalid %0d", k + 1), rv[k+1], (k % 2) == 1);
    end

    // VCU alone keeps the grant; a host request then wins the next tie.
    bus.h_req = 1'b0; bus.v_req = 1'b1;
    cnt = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      cnt += int'(obs_vg);
    end
    check("v streak grants", cnt, 3);
    bus.h_req = 1'b1;
    tick();
    check("tie after streak h_gnt", obs_hg, 1'b1);
    check("tie after streak v_gnt", obs_vg, 1'b0);

    // vcu_done alongside a VCU grant, then host reads results in DONE.
    bus.h_req = 1'b0; bus.v_req = 1'b1; vcu_done = 1'b1;
    tick();
    check("done-cycle v_gnt", obs_vg, 1'b1);
    vcu_done = 1'b0; bus.h_req = 1'b1; bus.h_we = 4'h0; bus.h_addr = 32'h10;
    tick();
    check("done flag", obs_done, 1'b1);
    check("done v_gnt", obs_vg, 1'b0);
    check("done h_gnt", obs_hg, 1'b1);
    check("done read addr", obs_addr, 32'h10);
    bus.h_req = 1'b0;
    tick();
    check("readback rvalid", obs_hrv, 1'b1);
    check("readback data", obs_hrdata, 32'hDEADBEEF);
    mem_wrt_done = 1'b0;
    tick();
    tick();
    check("back to load done", obs_done, 1'b0);
    check("back to load v_gnt", obs_vg, 1'b0);

    // Randomized traffic against the model.
    for (int i = 0; i < 400; i++) begin
      bus.h_req = ($urandom_range(0, 3) != 0);
      bus.v_req = ($urandom_range(0, 3) != 0);
      bus.h_we = ($urandom_range(0, 1) == 1) ? 4'($urandom()) : 4'h0;
      bus.v_we = ($urandom_range(0, 1) == 1) ? 4'($urandom()) : 4'h0;
      bus.h_addr = 32'($urandom_range(0, 63));
      bus.v_addr = 32'($urandom_range(0, 63));
      bus.h_wdata = $urandom();
      bus.v_wdata = $urandom();
      if ($urandom_range(0, 15) == 0) mem_wrt_done = ~mem_wrt_done;
      vcu_done = ($urandom_range(0, 11) == 0);
      rst = ($urandom_range(0, 149) == 0);
      tick();
    end
    rst = 1'b0;

    // RD_LAT=2 instance: latency, drain before RUN, reset during a pending read.
    @(posedge clk); #1;
    rst2 = 1'b0;
    bus2.h_req = 1'b1; bus2.h_we = 4'h0; bus2.h_addr = 32'h42;
    @(negedge clk);
    check("d2 h_gnt", bus2.h_gnt, 1'b1);
    check("d2 addr", addr2, 32'h40);
    @(posedge clk); #1;
    bus2.h_req = 1'b0; mwd2 = 1'b1;
    @(negedge clk);
    check("d2 h_rvalid +1", bus2.h_rvalid, 1'b0);
    check("d2 start while pending", start2, 1'b0);
    @(posedge clk); #1;
    din2 = 32'hCAFEF00D;
    @(negedge clk);
    check("d2 h_rvalid +2", bus2.h_rvalid, 1'b1);
    check("d2 h_rdata", bus2.h_rdata, 32'hCAFEF00D);
    check("d2 start while draining", start2, 1'b0);
    @(posedge clk); #1;
    @(negedge clk);
    check("d2 h_rvalid +3", bus2.h_rvalid, 1'b0);
    check("d2 start before run", start2, 1'b0);
    @(posedge clk); #1;
    bus2.v_req = 1'b1;
    @(negedge clk);
    check("d2 vcu_start", start2, 1'b1);
    check("d2 run v_gnt", bus2.v_gnt, 1'b1);
    @(posedge clk); #1;
    @(negedge clk);
    check("d2 read v_gnt", bus2.v_gnt, 1'b1);
    @(posedge clk); #1;
    bus2.h_req = 1'b1; bus2.v_req = 1'b1;
    #2;
    rst2 = 1'b1;
    #1;
    check("d2 rst h_gnt", bus2.h_gnt, 1'b0);
    check("d2 rst v_gnt", bus2.v_gnt, 1'b0);
    check("d2 rst BRAMENMEM", en2, 1'b0);
    check("d2 rst BRAMWREN", wren2, 4'h0);
    check("d2 rst BRAMaddrByte", addr2, 32'h0);
    check("d2 rst BRAMDataOut", dout2, 32'h0);
    check("d2 rst vcu_start", start2, 1'b0);
    check("d2 rst done", done2, 1'b0);
    check("d2 rst h_rdata", bus2.h_rdata, 32'h0);
    check("d2 rst v_rvalid", bus2.v_rvalid, 1'b0);
    @(posedge clk); #1;
    rst2 = 1'b0; mwd2 = 1'b0; bus2.h_req = 1'b0; bus2.v_req = 1'b1;
    @(negedge clk);
    check("d2 dropped v_rvalid", bus2.v_rvalid, 1'b0);
    check("d2 dropped h_rvalid", bus2.h_rvalid, 1'b0);
    check("d2 post-rst v_gnt", bus2.v_gnt, 1'b0);
    check("d2 post-rst done", done2, 1'b0);
    @(posedge clk); #1;
    bus2.h_req = 1'b1; bus2.v_req = 1'b0;
    @(negedge clk);
    check("d2 post-rst h_gnt", bus2.h_gnt, 1'b1);
    check("d2 post-rst BRAMENMEM", en2, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end
endmodule
